// File: rtl/wb_pkg.sv
// Shared types for the writeback/SAD-select slice: FSM states, source and
// load-format encodings, and the load formatting helper.
package wb_pkg;

  localparam int N_SAD  = 8;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    WRITE_VAL = 3'd2,
    WRITE_IDX = 3'd3,
    FINISH    = 3'd4
  } state_e;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_LOAD = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;
  localparam logic [1:0] M2R_RS   = 2'b11;

  localparam logic [1:0] LD_WORD   = 2'b00;
  localparam logic [1:0] LD_HALF_S = 2'b01;
  localparam logic [1:0] LD_BYTE_S = 2'b10;
  localparam logic [1:0] LD_BYTE_Z = 2'b11;

  function automatic logic [DATA_W-1:0] load_format(input logic [1:0] mux,
                                                    input logic [DATA_W-1:0] mem);
    logic [DATA_W-1:0] r;
    case (mux)
      LD_HALF_S: r = {{(DATA_W-16){mem[15]}}, mem[15:0]};
      LD_BYTE_S: r = {{(DATA_W-8){mem[7]}}, mem[7:0]};
      LD_BYTE_Z: r = {{(DATA_W-8){1'b0}}, mem[7:0]};
      default:   r = mem;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sad_cmp_unit.sv
// Min/max select of two indexed SAD values. b wins only when strictly better,
// or on a tie when it carries the lower index.
module sad_cmp_unit
  import wb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             find_max,
  input  logic [DW-1:0]    a_val,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [DW-1:0]    b_val,
  input  logic [IDX_W-1:0] b_idx,
  output logic [DW-1:0]    w_val,
  output logic [IDX_W-1:0] w_idx
);

  logic take_b;

  always_comb begin
    take_b = find_max ? (b_val > a_val) : (b_val < a_val);
    if ((b_val == a_val) && (b_idx < a_idx)) take_b = 1'b1;
    w_val = take_b ? b_val : a_val;
    w_idx = take_b ? b_idx : a_idx;
  end

endmodule

// File: rtl/wb_sad_select.sv
// Writeback stage with RF write port arbitration and a SAD min/max finder.
// Define WB_SAD_PARALLEL_EN for a single-cycle compare tree instead of the serial scan.
module wb_sad_select
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWrite,
  input  logic [1:0]         MemToReg,
  input  logic [1:0]         LoadMux,
  input  logic [DW-1:0]      ALUResult,
  input  logic [DW-1:0]      MemContent,
  input  logic [DW-1:0]      PCplus4,
  input  logic [DW-1:0]      Rs,
  input  logic [AW-1:0]      RdAddress,
  input  logic               allow_find,
  input  logic               small_big_find,
  input  logic               write_min,
  input  logic [N_SAD*DW-1:0] sad_flat,
  output logic               wb_we,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  output logic               stall,
  output logic [DW-1:0]      best_val,
  output logic [IDX_W-1:0]   best_idx,
  output logic               done,
  output logic               overflow,
  output logic [2:0]         dbg_state
);

  state_e             state_q, state_d;
  logic [N_SAD*DW-1:0] buf_q, buf_d;
  logic               find_max_q, find_max_d, write_min_q, write_min_d;
  logic [DW-1:0]      rs_q, rs_d, cur_val_q, cur_val_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d, i_q, i_d;
  logic               pend_v_q, pend_v_d;
  logic [AW-1:0]      pend_addr_q, pend_addr_d;
  logic [DW-1:0]      pend_data_q, pend_data_d;
  logic               wb_we_q, wb_we_d, done_q, done_d, overflow_q, overflow_d;
  logic [AW-1:0]      wb_addr_q, wb_addr_d;
  logic [DW-1:0]      wb_data_q, wb_data_d, best_val_q, best_val_d, sel_data;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [DW-1:0]      scan_val;
  logic [IDX_W-1:0]   scan_idx;

`ifdef WB_SAD_PARALLEL_EN
  // Nodes 0..7 are the entries; node 8+n merges nodes 2n and 2n+1; node 14 is the root.
  logic [DW-1:0]    node_val [0:14];
  logic [IDX_W-1:0] node_idx [0:14];
  for (genvar k = 0; k < N_SAD; k++) begin : g_leaf
    assign node_val[k] = buf_q[k*DW +: DW];
    assign node_idx[k] = IDX_W'(k);
  end
  for (genvar n = 0; n < N_SAD - 1; n++) begin : g_tree
    sad_cmp_unit #(.DW(DW)) u_cmp (
      .find_max (find_max_q),
      .a_val    (node_val[2*n]),   .a_idx (node_idx[2*n]),
      .b_val    (node_val[2*n+1]), .b_idx (node_idx[2*n+1]),
      .w_val    (node_val[N_SAD+n]), .w_idx (node_idx[N_SAD+n])
    );
  end
  assign scan_val = node_val[14];
  assign scan_idx = node_idx[14];
`else
  sad_cmp_unit #(.DW(DW)) u_cmp (
    .find_max (find_max_q),
    .a_val    (cur_val_q),            .a_idx (cur_idx_q),
    .b_val    (buf_q[i_q*DW +: DW]),  .b_idx (i_q),
    .w_val    (scan_val),             .w_idx (scan_idx)
  );
`endif

  always_comb begin
    case (MemToReg)
      M2R_LOAD: sel_data = load_format(LoadMux, MemContent);
      M2R_PC4:  sel_data = PCplus4;
      M2R_RS:   sel_data = Rs;
      default:  sel_data = ALUResult;
    endcase
  end

  always_comb begin
    state_d = state_q;  buf_d = buf_q;  find_max_d = find_max_q;
    write_min_d = write_min_q;  rs_d = rs_q;  rd_d = rd_q;
    cur_val_d = cur_val_q;  cur_idx_d = cur_idx_q;  i_d = i_q;
    pend_v_d = pend_v_q;  pend_addr_d = pend_addr_q;  pend_data_d = pend_data_q;
    wb_we_d = 1'b0;  wb_addr_d = wb_addr_q;  wb_data_d = wb_data_q;
    best_val_d = best_val_q;  best_idx_d = best_idx_q;
    done_d = 1'b0;  overflow_d = overflow_q;

    // While busy, a normal write parks in the one-entry slot or is lost.
    if (state_q != IDLE && RegWrite) begin
      if (pend_v_q) begin
        overflow_d = 1'b1;
      end else begin
        pend_v_d    = 1'b1;
        pend_addr_d = RdAddress;
        pend_data_d = sel_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (RegWrite) begin
          wb_we_d   = (RdAddress != '0);
          wb_addr_d = RdAddress;
          wb_data_d = sel_data;
        end
        if (allow_find) begin
          buf_d       = sad_flat;
          find_max_d  = small_big_find;
          write_min_d = write_min;
          rs_d        = Rs;
          rd_d        = RdAddress;
          cur_val_d   = sad_flat[DW-1:0];
          cur_idx_d   = '0;
          i_d         = IDX_W'(1);
          state_d     = SCAN;
        end
      end
      SCAN: begin
        cur_val_d = scan_val;
        cur_idx_d = scan_idx;
        i_d       = i_q + IDX_W'(1);
`ifdef WB_SAD_PARALLEL_EN
        state_d = write_min_q ? WRITE_VAL : FINISH;
`else
        if (i_q == IDX_W'(N_SAD - 1)) state_d = write_min_q ? WRITE_VAL : FINISH;
`endif
      end
      WRITE_VAL: begin
        wb_we_d   = (rd_q != '0);
        wb_addr_d = rd_q;
        wb_data_d = cur_val_q;
        state_d   = WRITE_IDX;
      end
      WRITE_IDX: begin
        wb_addr_d = rd_q + AW'(1);
        wb_we_d   = (wb_addr_d != '0);
        wb_data_d = rs_q + {{(DW-IDX_W){1'b0}}, cur_idx_q};
        state_d   = FINISH;
      end
      FINISH: begin
        best_val_d = cur_val_q;
        best_idx_d = cur_idx_q;
        done_d     = 1'b1;
        state_d    = IDLE;
        if (pend_v_q) begin
          wb_we_d   = (pend_addr_q != '0);
          wb_addr_d = pend_addr_q;
          wb_data_d = pend_data_q;
        end else if (RegWrite) begin
          wb_we_d   = (RdAddress != '0);
          wb_addr_d = RdAddress;
          wb_data_d = sel_data;
        end
        pend_v_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;  buf_q <= '0;  find_max_q <= 1'b0;  write_min_q <= 1'b0;
      rs_q <= '0;  rd_q <= '0;  cur_val_q <= '0;  cur_idx_q <= '0;  i_q <= '0;
      pend_v_q <= 1'b0;  pend_addr_q <= '0;  pend_data_q <= '0;
      wb_we_q <= 1'b0;  wb_addr_q <= '0;  wb_data_q <= '0;
      best_val_q <= '0;  best_idx_q <= '0;  done_q <= 1'b0;  overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;  buf_q <= buf_d;  find_max_q <= find_max_d;
      write_min_q <= write_min_d;  rs_q <= rs_d;  rd_q <= rd_d;
      cur_val_q <= cur_val_d;  cur_idx_q <= cur_idx_d;  i_q <= i_d;
      pend_v_q <= pend_v_d;  pend_addr_q <= pend_addr_d;  pend_data_q <= pend_data_d;
      wb_we_q <= wb_we_d;  wb_addr_q <= wb_addr_d;  wb_data_q <= wb_data_d;
      best_val_q <= best_val_d;  best_idx_q <= best_idx_d;
      done_q <= done_d;  overflow_q <= overflow_d;
    end
  end

  // stall: valid while a find is starting or running; forced low in reset.
  assign stall     = rst & ((state_q == IDLE && allow_find) || (state_q != IDLE));
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign best_val  = best_val_q;
  assign best_idx  = best_idx_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
